// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready handshake; shifts iterate one bit per cycle.
// Define ALU_MC_MUL_EN to compile in the shift-add multiplier (op 1100); otherwise 1100 is illegal.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
`ifdef ALU_MC_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1100;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef ALU_MC_MUL_EN
    MUL   = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sop_q, sop_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] shifted_s;
  logic [SHW-1:0]   shamt_s;
`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] sum_s;
`endif

  assign shamt_s = b[SHW-1:0];

  // One-bit shift step; sop_q holds op[1:0] of the captured shift (01 SLL, 10 SRL, 11 SRA).
  always_comb begin
    case (sop_q)
      2'b01:   shifted_s = {acc_q[WIDTH-2:0], 1'b0};
      2'b10:   shifted_s = {1'b0, acc_q[WIDTH-1:1]};
      2'b11:   shifted_s = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: shifted_s = acc_q;
    endcase
  end

`ifdef ALU_MC_MUL_EN
  // Shift-add partial sum for the current multiplier bit.
  always_comb begin
    if (mplr_q[0]) begin
      sum_s = acc_q + mcand_q;
    end else begin
      sum_s = acc_q;
    end
  end
`endif

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sop_q       <= 2'b00;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_MC_MUL_EN
      mcand_q     <= '0;
      mplr_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sop_q       <= sop_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_MC_MUL_EN
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
`endif
    end
  end

  // Next-state and datapath updates; result is only rewritten on entry to DONE.
  always_comb begin
    state_d   = state_q;
    sop_d     = sop_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifdef ALU_MC_MUL_EN
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          illegal_d = 1'b0;
          state_d   = DONE;
          case (op)
            OP_AND:  result_d = a & b;
            OP_OR:   result_d = a | b;
            OP_ADD:  result_d = a + b;
            OP_XOR:  result_d = a ^ b;
            OP_SUB:  result_d = a - b;
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL, OP_SRL, OP_SRA: begin
              sop_d = op[1:0];
              acc_d = a;
              cnt_d = CW'(shamt_s);
              if (shamt_s == '0) begin
                result_d = a;
              end else begin
                state_d = SHIFT;
              end
            end
`ifdef ALU_MC_MUL_EN
            OP_MUL: begin
              acc_d   = '0;
              mcand_d = a;
              mplr_d  = b;
              cnt_d   = CW'(WIDTH);
              state_d = MUL;
            end
`endif
            default: begin
              result_d  = '0;
              illegal_d = 1'b1;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = shifted_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = shifted_s;
          state_d  = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
`ifdef ALU_MC_MUL_EN
      MUL: begin
        acc_d   = sum_s;
        mcand_d = {mcand_q[WIDTH-2:0], 1'b0};
        mplr_d  = {1'b0, mplr_q[WIDTH-1:1]};
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = sum_s;
          state_d  = DONE;
        end else begin
          state_d = MUL;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so handshake outputs come straight from flops.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    zero_d      = (result_d == '0);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; legal values are powers of two, 8..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port op  input  4  alu_op_t-compatible operation code.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B (shift amount in b[log2(WIDTH)-1:0] for shifts).
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have port zero  output  1  result == 0.
REQ-013 SHALL have port illegal  output  1  op was not a supported encoding.

Function
REQ-014 SHALL decode op: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLTU 1000, SLL 1001, SRL 1010, SRA 1011, MUL 1100; all others illegal.
REQ-015 SHALL implement FSM states IDLE, SHIFT, MUL, DONE; in_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a cycle with in_valid & in_ready, capturing op, a, b; inputs ignored in all other cycles.
REQ-017 SHALL, for AND/OR/XOR/ADD/SUB/SLT/SLTU/illegal, go IDLE -> DONE; out_valid asserted the cycle after acceptance (latency 1).
REQ-018 SHALL wrap ADD/SUB modulo 2^WIDTH; SLT signed compare, SLTU unsigned compare, result 1 or 0 zero-extended.
REQ-019 SHALL perform shifts iteratively one bit per cycle in SHIFT; shamt N>0 gives out_valid N+1 cycles after acceptance; N=0 goes directly to DONE (latency 1) with result = a.
REQ-020 SHALL fill with zeros for SLL/SRL and with a[WIDTH-1] for SRA.
REQ-021 SHALL drive result = 0 and illegal = 1 for illegal op; illegal = 0 for every supported op.
REQ-022 SHALL hold result, zero, illegal stable and out_valid = 1 in DONE until out_ready = 1, then go to IDLE on that edge.
REQ-023 SHALL keep in_ready = 0 in DONE even when out_ready = 1 (no same-cycle accept; next accept one cycle later).
REQ-024 SHALL drive out_valid = 0 in IDLE, SHIFT, MUL; result/zero/illegal undefined-but-stable outside DONE are not checked.
REQ-025 SHALL never assert in_ready and out_valid in the same cycle.

Reset
REQ-026 SHALL, on rst = 1 at a clock edge, enter IDLE from any state, abandoning any in-flight operation.
REQ-027 SHALL drive after reset: in_ready = 1, out_valid = 0, result = 0, zero = 1, illegal = 0.
REQ-028 SHALL give rst priority over in_valid and out_ready in the same cycle.

Configuration
REQ-029 SHALL use macro ALU_MC_MUL_EN to compile the MUL operation in or out.
REQ-030 SHALL, with ALU_MC_MUL_EN defined, compute MUL by shift-add in MUL state, one multiplier bit per cycle, out_valid exactly WIDTH+1 cycles after acceptance, result = low WIDTH bits of a*b.
REQ-031 SHALL, without ALU_MC_MUL_EN, treat op 1100 as illegal (result 0, illegal 1, latency 1) and contain no MUL state logic.

Verification
REQ-032 SHALL cover: WIDTH=32, ADD a=0xFFFFFFFF b=1 -> result 0x0, zero=1, out_valid one cycle after accept.
REQ-033 SHALL cover: SRA a=0x80000000 b=31 -> result 0xFFFFFFFF after 32 cycles; SLL b=0 -> result=a after 1 cycle.
REQ-034 SHALL cover: SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0.
REQ-035 SHALL cover: out_ready held 0 for 5 cycles in DONE -> result stable, in_ready 0, in_valid requests ignored; release -> IDLE next cycle.
REQ-036 SHALL cover: rst asserted mid-SHIFT (b=20, cycle 5) -> IDLE, out_valid 0, result 0 next cycle; no stale result emitted.
REQ-037 SHALL cover: op 1100 a=7 b=6 -> 42 after WIDTH+1 cycles with ALU_MC_MUL_EN; illegal=1, result 0 after 1 cycle without.
